obi_popcount_reader: RTL and testbench

//  OBI manager that reads NumWords consecutive 32-bit words from SRAM, starting at a base address.
//  It accumulates the number of set bits across every returned rdata word.
//  It is the initiator-side counterpart of the user-domain OBI subordinate and sits on a user-domain manager port of the crossbar.

---
 rtl/obi_popcount_reader_pkg.sv | 52 +++++
 rtl/obi_popcount_reader_popcount.sv | 25 ++
 rtl/obi_popcount_reader.sv | 149 ++++++++++++++
 tb/tb_obi_popcount_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_popcount_reader_pkg.sv
// ============================================================================
// Module : obi_popcount_reader_pkg
// Brief  : Types and constants shared by the OBI popcount reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package obi_popcount_reader_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 1;
  localparam bit          UseRReady = 1'b1;

  localparam logic [AddrWidth-1:0] WordStride = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

`default_nettype wire

// File: rtl/obi_popcount_reader_popcount.sv
// ============================================================================
// Module : obi_popcount_reader_popcount
// Brief  : Combinational count of set bits in one input word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module obi_popcount_reader_popcount #(
  parameter int unsigned INPUT_WIDTH = 32,
  localparam int unsigned POP_WIDTH  = $clog2(INPUT_WIDTH + 1)
) (
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic [POP_WIDTH-1:0]   popcount_o
);

  always_comb begin
    popcount_o = '0;
    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
      popcount_o = popcount_o + POP_WIDTH'(data_i[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/obi_popcount_reader.sv
// ============================================================================
// Module : obi_popcount_reader
// Brief  : OBI manager reading consecutive words and summing their set bits.
//          Optional OBI_POPCOUNT_READER_ABORT_ON_ERR_EN ends a job on r.err.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module obi_popcount_reader
  import obi_popcount_reader_pkg::*;
#(
  parameter int unsigned MaxWords = 256,
  localparam int unsigned LenW    = $clog2(MaxWords + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenW-1:0]      num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          popcount_o,
  output obi_req_t             obi_req_o,
  input  obi_rsp_t             obi_rsp_i
);

  localparam int unsigned PopW = $clog2(DataWidth + 1);

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenW-1:0]      rem_q, rem_d;
  logic [31:0]          acc_q, acc_d;
  logic [31:0]          pop_q, pop_d;
  logic                 err_q, err_d;

  logic [LenW-1:0] len_clamped;
  logic [PopW-1:0] word_pop;
  logic            start_acc;
  logic            beat;
  logic            abort_beat;
  logic            unused_rsp;

  assign len_clamped = (num_words_i > LenW'(MaxWords)) ? LenW'(MaxWords) : num_words_i;
  assign start_acc   = (state_q == IDLE) && start_i;
  // rvalid outside WAIT_R (e.g. a stale response after reset) is ignored
  assign beat        = (state_q == WAIT_R) && obi_rsp_i.rvalid;
  assign unused_rsp  = ^obi_rsp_i.r.rid;

`ifdef OBI_POPCOUNT_READER_ABORT_ON_ERR_EN
  assign abort_beat = beat && obi_rsp_i.r.err;
`else
  assign abort_beat = 1'b0;
`endif

  obi_popcount_reader_popcount #(
    .INPUT_WIDTH(DataWidth)
  ) u_popcount (
    .data_i    (obi_rsp_i.r.rdata),
    .popcount_o(word_pop)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = (len_clamped == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (obi_rsp_i.gnt) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (beat) begin
          state_d = ((rem_q == LenW'(1)) || abort_beat) ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obi_req_o        = '0;
    obi_req_o.req    = (state_q == REQ);
    obi_req_o.a.addr = addr_q;
    obi_req_o.a.we   = 1'b0;
    obi_req_o.a.be   = '1;
    obi_req_o.rready = UseRReady && (state_q == WAIT_R);
    busy_o           = (state_q != IDLE);
    done_o           = (state_q == DONE);
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    acc_d  = acc_q;
    err_d  = err_q;
    pop_d  = pop_q;
    if (start_acc) begin
      addr_d = base_addr_i;
      rem_d  = len_clamped;
      acc_d  = '0;
      err_d  = 1'b0;
    end else if (beat) begin
      acc_d  = acc_q + 32'(word_pop);
      err_d  = err_q | obi_rsp_i.r.err;
      rem_d  = rem_q - LenW'(1);
      addr_d = addr_q + WordStride;
    end
    // Publish the total together with the done pulse
    if ((state_d == DONE) && (state_q != DONE)) begin
      pop_d = acc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
      pop_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      acc_q  <= acc_d;
      err_q  <= err_d;
      pop_q  <= pop_d;
    end
  end

  assign err_o      = err_q;
  assign popcount_o = pop_q;

endmodule

`default_nettype wire

// File: tb/tb_obi_popcount_reader.sv
// ============================================================================
// Module : tb_obi_popcount_reader
// Brief  : Randomized bench for obi_popcount_reader with an SRAM-style
//          subordinate and a word-list reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_obi_popcount_reader;
  import obi_popcount_reader_pkg::*;

  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned LEN_W     = $clog2(MAX_WORDS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] num_words;
  logic             busy, done, err;
  logic [31:0]      popcount;
  obi_req_t         obi_req;
  obi_rsp_t         rsp;

  always #5 clk = ~clk;

  obi_popcount_reader #(
    .MaxWords(MAX_WORDS)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_addr_i(base_addr),
    .num_words_i(num_words),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .popcount_o (popcount),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (rsp)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F ^ (a * 32'h9E37_79B1);
  endfunction

  // Subordinate state shared with the job driver
  logic [31:0] read_log[$];
  int          rd_idx       = 0;
  int          err_idx      = -1;
  int          gnt_first    = -1;
  int          fixed_rdelay = -1;
  bit          pend         = 1'b0;
  int          pend_delay   = 0;
  logic [31:0] pend_addr    = '0;
  bit          pend_err     = 1'b0;
  bit          waiting      = 1'b0;
  int          wait_left    = 0;

  initial begin : slave
    obi_a_chan_t cap;
    cap = '0;
    rsp = '0;
    forever begin
      @(negedge clk);
      rsp = '0;
      if (pend) begin
        if (pend_delay == 0) begin
          rsp.rvalid  = 1'b1;
          rsp.r.rdata = mem_rd(pend_addr);
          rsp.r.err   = pend_err;
          pend        = 1'b0;
        end else begin
          pend_delay--;
        end
      end else if (rst) begin
        waiting = 1'b0;
      end else if (obi_req.req) begin
        if (!waiting) begin
          waiting   = 1'b1;
          cap       = obi_req.a;
          wait_left = (gnt_first >= 0 && rd_idx == 0) ? gnt_first : int'($urandom_range(0, 2));
        end else begin
          check("a_addr_hold", obi_req.a.addr, cap.addr);
        end
        check("a_ctrl", {27'd0, obi_req.a.we, obi_req.a.be}, 32'h0000_000F);
        if (wait_left == 0) begin
          rsp.gnt = 1'b1;
          read_log.push_back(obi_req.a.addr);
          pend       = 1'b1;
          pend_addr  = obi_req.a.addr;
          pend_err   = (rd_idx == err_idx);
          pend_delay = (fixed_rdelay >= 0) ? fixed_rdelay : int'($urandom_range(0, 2));
          rd_idx++;
          waiting = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input int len, input int eidx,
                         input int gfirst, input bit poke);
    int          n;
    int          cyc;
    logic [31:0] acc;
    logic [31:0] a;
    bit          e;
    logic [31:0] exp_addr[$];

    n   = (len > int'(MAX_WORDS)) ? int'(MAX_WORDS) : len;
    acc = '0;
    e   = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      exp_addr.push_back(a);
      acc = acc + 32'($countones(mem_rd(a)));
      if (i == eidx) begin
        e = 1'b1;
`ifdef OBI_POPCOUNT_READER_ABORT_ON_ERR_EN
        break;
`endif
      end
    end

    @(negedge clk);
    read_log.delete();
    rd_idx    = 0;
    err_idx   = eidx;
    gnt_first = gfirst;
    start     = 1'b1;
    base_addr = base;
    num_words = LEN_W'(len);
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
    num_words = LEN_W'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);

    cyc = 1;
    while (!done && cyc < 4000) begin
      start = poke && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    if (len == 0) check("len0_done_latency", {31'd0, cyc <= 2}, 32'd1);
    check("err_at_done", {31'd0, err}, {31'd0, e});
    check("n_reads", 32'(read_log.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < read_log.size(); i++) begin
      check("read_addr", read_log[i], exp_addr[i]);
    end

    @(negedge clk);
    check("done_one_pulse", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("popcount", popcount, acc);
    check("err_held", {31'd0, err}, {31'd0, e});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

  initial begin : main
    int len;
    int c;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    mem[32'h1000_0000] = 32'hFFFF_FFFF;
    mem[32'h1000_0004] = 32'h0000_0000;
    mem[32'h1000_0008] = 32'h0000_000F;
    mem[32'h1000_000C] = 32'h8000_0001;
    for (int i = 0; i < 3; i++) mem[32'h3000_0000 + 32'(4 * i)] = 32'h0000_00FF;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_popcount", popcount, 32'd0);
    check("rst_req", {31'd0, obi_req.req}, 32'd0);
    rst = 1'b0;

    // Directed: four words, immediate grant
    run_job(32'h1000_0000, 4, -1, 0, 1'b0);
    check("t1_popcount_38", popcount, 32'd38);
    // Zero-length job
    run_job(32'h4000_0000, 0, -1, -1, 1'b0);
    // Grant stalled three cycles on the first request
    run_job(32'h1000_0000, 2, -1, 3, 1'b1);
    // Error on the second of three 0xFF words
    run_job(32'h3000_0000, 3, 1, -1, 1'b0);
`ifdef OBI_POPCOUNT_READER_ABORT_ON_ERR_EN
    check("t4_popcount", popcount, 32'd16);
`else
    check("t4_popcount", popcount, 32'd24);
`endif
    // Address wrap past the top of the space
    run_job(32'hFFFF_FFFC, 2, -1, -1, 1'b0);
    if (read_log.size() == 2) check("wrap_addr", read_log[1], 32'h0000_0000);
    else check("wrap_reads", 32'(read_log.size()), 32'd2);

    // Reset while waiting for a response; the late rvalid must be ignored
    fixed_rdelay = 3;
    @(negedge clk);
    read_log.delete();
    rd_idx    = 0;
    err_idx   = -1;
    gnt_first = 0;
    start     = 1'b1;
    base_addr = 32'h1000_0000;
    num_words = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (c < 50) begin
      @(posedge clk);
      if (rsp.gnt) break;
      c++;
    end
    check("rst_test_gnt_seen", {31'd0, c < 50}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midjob_rst_req", {31'd0, obi_req.req}, 32'd0);
    check("midjob_rst_busy", {31'd0, busy}, 32'd0);
    check("midjob_rst_done", {31'd0, done}, 32'd0);
    check("midjob_rst_popcount", popcount, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("late_rvalid_busy", {31'd0, busy}, 32'd0);
    check("late_rvalid_popcount", popcount, 32'd0);
    fixed_rdelay = -1;
    run_job(32'h1000_0000, 4, -1, -1, 1'b1);

    // Randomized back-to-back jobs, including clamped lengths and errors
    for (int j = 0; j < 30; j++) begin
      len = int'($urandom_range(0, 24));
      run_job($urandom & 32'hFFFF_FFFC, len,
              (($urandom % 3) == 0) ? int'($urandom_range(0, len)) : -1,
              -1, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
